// File: rtl/pipelined_adder_tree.sv
// Pipelined N-input adder tree with one register stage per level and a global-stall
// valid/ready handshake. The result is always full precision, so it never overflows.
module pipelined_adder_tree #(
  parameter int N_INPUTS = 4,
  parameter int IN_WIDTH = 8,
  parameter bit SIGNED   = 1'b0,
  localparam int LEVELS    = $clog2(N_INPUTS),
  localparam int SUM_WIDTH = IN_WIDTH + LEVELS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_INPUTS*IN_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SUM_WIDTH-1:0]         out_sum
);

  if (N_INPUTS < 2 || (1 << LEVELS) != N_INPUTS) begin : g_bad_n
    $error("pipelined_adder_tree: N_INPUTS must be a power of two >= 2");
  end
  if (IN_WIDTH < 1) begin : g_bad_w
    $error("pipelined_adder_tree: IN_WIDTH must be >= 1");
  end

  // The whole pipeline moves together. It advances whenever the output slot is empty or is being drained.
  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 1; k <= LEVELS; k++) begin : lvl
    localparam int W   = IN_WIDTH + k;
    localparam int CNT = N_INPUTS >> k;

    logic prev_valid;
    logic valid_q;

    if (k == 1) begin : g_first
      assign prev_valid = in_valid;
    end else begin : g_rest
      assign prev_valid = lvl[k-1].valid_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else if (adv) begin
        valid_q <= prev_valid;
      end
    end

    for (genvar j = 0; j < CNT; j++) begin : add
      logic [W-2:0] a;
      logic [W-2:0] b;
      logic [W-1:0] a_ext;
      logic [W-1:0] b_ext;
      logic [W-1:0] sum_q;

      if (k == 1) begin : g_lanes
        assign a = in_data[(2*j)*IN_WIDTH +: IN_WIDTH];
        assign b = in_data[(2*j+1)*IN_WIDTH +: IN_WIDTH];
      end else begin : g_nodes
        assign a = lvl[k-1].add[2*j].sum_q;
        assign b = lvl[k-1].add[2*j+1].sum_q;
      end

      // Widen by exactly one bit per level, so the add at this level cannot overflow.
      assign a_ext = SIGNED ? {a[W-2], a} : {1'b0, a};
      assign b_ext = SIGNED ? {b[W-2], b} : {1'b0, b};

      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q <= '0;
        end else if (adv) begin
          sum_q <= a_ext + b_ext;
        end
      end
    end
  end

  assign out_valid = lvl[LEVELS].valid_q;
  assign out_sum   = lvl[LEVELS].add[0].sum_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed self-checking bench for pipelined_adder_tree: default, signed and 8-lane builds,
// with a scoreboard that tracks acceptance order on the default build.
module tb_pipelined_adder_tree;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [9:0]  out_sum;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [31:0] s_in_data = '0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b1;
  logic [9:0]  s_out_sum;

  logic        p_in_valid = 1'b0;
  logic        p_in_ready;
  logic [31:0] p_in_data = '0;
  logic        p_out_valid;
  logic        p_out_ready = 1'b1;
  logic [6:0]  p_out_sum;

  int check_count = 0;
  int pass_count  = 0;
  int pushed      = 0;
  int popped      = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  pipelined_adder_tree u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  pipelined_adder_tree #(.N_INPUTS(4), .IN_WIDTH(8), .SIGNED(1'b1)) u_sdut (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum)
  );

  pipelined_adder_tree #(.N_INPUTS(8), .IN_WIDTH(4), .SIGNED(1'b0)) u_pdut (
    .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_sum(p_out_sum)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    logic [7:0] la, lb, lc, ld;
    la = 8'(a); lb = 8'(b); lc = 8'(c); ld = 8'(d);
    return {ld, lc, lb, la};
  endfunction

  function automatic int model_sum(input logic [31:0] d);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += int'(d[i*8 +: 8]);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] data);
    in_valid = valid;
    in_data  = data;
  endtask

  // Scoreboard: sample at negedge, when inputs and outputs are settled for the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_unexpected_result", 32'(out_sum), 32'hFFFF_FFFF);
        end else begin
          checkOutput("sb_order", 32'(out_sum), 32'(exp_q.pop_front()));
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_sum(in_data));
        pushed++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic        bubble_pat [4];
    bubble_pat[0] = 1'b1; bubble_pat[1] = 1'b0; bubble_pat[2] = 1'b1; bubble_pat[3] = 1'b0;

    // Reset
    #1;
    step(); step();
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_sum", 32'(out_sum), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();

    // Unsigned max then {3,0,1,255}
    applyStimulus(1'b1, pack4(255, 255, 255, 255));
    step();
    applyStimulus(1'b1, pack4(3, 0, 1, 255));
    checkOutput("max_not_yet_valid", 32'(out_valid), 32'd0);
    step();
    applyStimulus(1'b0, '0);
    checkOutput("max_valid", 32'(out_valid), 32'd1);
    checkOutput("max_sum", 32'(out_sum), 32'd1020);
    step();
    checkOutput("second_valid", 32'(out_valid), 32'd1);
    checkOutput("second_sum", 32'(out_sum), 32'd259);
    step();
    checkOutput("drained_valid", 32'(out_valid), 32'd0);

    // Streaming: 16 back-to-back random sets
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, $urandom);
      #1;
      checkOutput("stream_in_ready", 32'(in_ready), 32'd1);
      step();
    end
    applyStimulus(1'b0, '0);
    for (int i = 0; i < 3; i++) step();
    checkOutput("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure
    applyStimulus(1'b1, pack4(255, 255, 255, 255));
    step();
    applyStimulus(1'b1, pack4(1, 2, 3, 4));
    step();
    applyStimulus(1'b1, pack4(5, 6, 7, 8));
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_out_sum", 32'(out_sum), 32'd1020);
      step();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
    step();
    applyStimulus(1'b0, '0);
    checkOutput("bp_next_sum", 32'(out_sum), 32'd10);
    step();
    checkOutput("bp_held_set_sum", 32'(out_sum), 32'd26);
    checkOutput("bp_held_set_valid", 32'(out_valid), 32'd1);
    step(); step();
    checkOutput("bp_drained", 32'(exp_q.size()), 32'd0);

    // Bubbles
    for (int i = 0; i < 6; i++) begin
      applyStimulus((i < 4) ? bubble_pat[i] : 1'b0, pack4(i, i, i, i));
      step();
      if (i >= 1 && i <= 4) checkOutput("bubble_out_valid", 32'(out_valid), 32'(bubble_pat[i-1]));
    end

    // Reset mid-flight
    applyStimulus(1'b1, pack4(9, 9, 9, 9));
    step();
    applyStimulus(1'b1, pack4(7, 7, 7, 7));
    step();
    rst = 1'b1;
    applyStimulus(1'b1, pack4(50, 50, 50, 50));
    step();
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_sum", 32'(out_sum), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, '0);
    step();
    checkOutput("midrst_no_ghost_1", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, pack4(1, 2, 3, 4));
    step();
    applyStimulus(1'b0, '0);
    checkOutput("midrst_no_ghost_2", 32'(out_valid), 32'd0);
    step();
    checkOutput("midrst_new_valid", 32'(out_valid), 32'd1);
    checkOutput("midrst_new_sum", 32'(out_sum), 32'd10);
    step();

    // Signed build
    s_in_valid = 1'b1;
    s_in_data  = pack4(-128, -128, -128, -128);
    step();
    s_in_data  = pack4(127, -1, 0, -126);
    step();
    s_in_valid = 1'b0;
    checkOutput("signed_min_valid", 32'(s_out_valid), 32'd1);
    checkOutput("signed_min_sum", 32'(s_out_sum), 32'h200);
    step();
    checkOutput("signed_zero_valid", 32'(s_out_valid), 32'd1);
    checkOutput("signed_zero_sum", 32'(s_out_sum), 32'd0);

    // 8-lane, 4-bit build: latency 3
    p_in_valid = 1'b1;
    p_in_data  = 32'hFFFF_FFFF;
    step();
    p_in_valid = 1'b0;
    step();
    checkOutput("param_lat_not_yet", 32'(p_out_valid), 32'd0);
    step();
    checkOutput("param_valid", 32'(p_out_valid), 32'd1);
    checkOutput("param_sum", 32'(p_out_sum), 32'd120);
    step();

    checkOutput("sb_all_consumed", 32'(popped), 32'(pushed - 2));
    checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
